// File: rtl/mmio_pkg.sv
// Shared constants for the Riscv151 memory-mapped I/O window: base nibble,
// register offsets and status register bit positions.
package mmio_pkg;

  localparam logic [3:0] MMIO_BASE_NIBBLE = 4'h8;

  localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
  localparam logic [7:0] MMIO_UART_RX   = 8'h04;
  localparam logic [7:0] MMIO_UART_TX   = 8'h08;
  localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
  localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

  localparam int unsigned STAT_TX_EMPTY_BIT   = 0;
  localparam int unsigned STAT_RX_NONEMPTY_BIT = 1;

  localparam int unsigned MMIO_DATA_W = 32;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Small synchronous FIFO buffering received UART bytes; head is visible
// combinationally on dout so a load can return it without extra latency.
module mmio_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Extra pointer MSB separates the full case from the empty case.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge for the 0x8000_00xx window: UART RX buffering, TX holding
// register, cycle/instruction counters and a one-cycle registered read port.
module uart_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE      = 115200,
  parameter int unsigned RX_FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  // Reject configurations the FIFO pointers or the UART cannot support.
  if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0 ||
      BAUD_RATE == 0 || CPU_CLOCK_FREQ < BAUD_RATE) begin : g_bad_cfg
    $error("uart_mmio_ctrl: invalid parameter set");
  end

  logic                   sel_c;
  logic [7:0]             off_c;
  logic                   rx_pop_c;
  logic                   rx_push_c;
  logic                   tx_wr_c;
  logic                   cnt_clr_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [7:0]             fifo_dout;
  logic [MMIO_DATA_W-1:0] rdata_nxt_c;
  logic [MMIO_DATA_W-1:0] cycle_cnt;
  logic [MMIO_DATA_W-1:0] inst_cnt;
  logic                   unused_bits_c;

  assign unused_bits_c = ^{addr[27:8], addr[1:0], wdata[31:8]};

  assign sel_c     = (addr[31:28] == MMIO_BASE_NIBBLE);
  assign off_c     = {addr[7:2], 2'b00};
  assign rx_pop_c  = re && sel_c && (off_c == MMIO_UART_RX) && !fifo_empty;
  // A pop frees a slot at the same edge, so a full FIFO may still take a byte.
  assign rx_push_c = rx_valid && (!fifo_full || rx_pop_c);
  assign rx_ready  = !fifo_full;
  assign tx_wr_c   = we && sel_c && (off_c == MMIO_UART_TX);
  assign cnt_clr_c = we && sel_c && (off_c == MMIO_CNT_RST);

  mmio_rx_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push_c),
    .pop   (rx_pop_c),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read mux reflects pre-edge state; anything outside the window reads 0.
  always_comb begin
    rdata_nxt_c = '0;
    if (sel_c) begin
      case (off_c)
        MMIO_UART_CTRL: begin
          rdata_nxt_c[STAT_TX_EMPTY_BIT]    = !tx_valid;
          rdata_nxt_c[STAT_RX_NONEMPTY_BIT] = !fifo_empty;
        end
        MMIO_UART_RX:   if (!fifo_empty) rdata_nxt_c = {24'b0, fifo_dout};
        MMIO_CYCLE_CNT: rdata_nxt_c = cycle_cnt;
        MMIO_INST_CNT:  rdata_nxt_c = inst_cnt;
        default:        rdata_nxt_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rdata_nxt_c;
  end

  // TX holding register: a write landing on the handshake edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end else if (!tx_valid && tx_wr_c) begin
      tx_valid <= 1'b1;
      tx_data  <= wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr_c) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + MMIO_DATA_W'(1);
      if (inst_retire) inst_cnt <= inst_cnt + MMIO_DATA_W'(1);
    end
  end

endmodule
